seq_modmult: RTL



---
 rtl/seq_modmult.sv | 104 ++++++++++
 1 files changed

// File: rtl/seq_modmult.sv
// seq_modmult: sequential MSB-first shift-add multiplier with optional
// interleaved modular reduction, one multiplier bit per clock.
module seq_modmult #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   m,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] raw_nxt;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   m_r;
  logic               mode_r;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH+1:0]   t;
  logic [WIDTH+1:0]   m_x1;
  logic [WIDTH+1:0]   m_x2;
  logic [WIDTH-1:0]   t_red;

  // One iteration: b_r is shifted left each cycle so its MSB is the current bit.
  always_comb begin
    a_sel   = b_r[WIDTH-1] ? a_r : '0;
    raw_nxt = {acc[2*WIDTH-2:0], 1'b0} + {{WIDTH{1'b0}}, a_sel};
    m_x1    = {2'b00, m_r};
    m_x2    = {1'b0, m_r, 1'b0};
    t       = {1'b0, acc[WIDTH-1:0], 1'b0} + {2'b00, a_sel};
    if (t >= m_x2) begin
      t_red = WIDTH'(t - m_x2);
    end else if (t >= m_x1) begin
      t_red = WIDTH'(t - m_x1);
    end else begin
      t_red = WIDTH'(t);
    end
    acc_nxt = mode_r ? {{WIDTH{1'b0}}, t_red} : raw_nxt;
  end

  // Control FSM, operand capture, accumulator and registered outputs.
  // A new start is refused while done is high so the earliest accept is the
  // cycle after the completion pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      m_r     <= '0;
      mode_r  <= 1'b0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done) begin
            a_r    <= a;
            b_r    <= b;
            m_r    <= m;
            mode_r <= mode;
            acc    <= '0;
            cnt    <= CNT_W'(WIDTH - 1);
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          b_r <= b_r << 1;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= FIN;
          end
        end
        FIN: begin
          product <= acc;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
